puf_response_ctrl: RTL and testbench

//  Measurement sequencer downstream of the RO-pair edge counters (Counter).
//  - Per response bit: select an oscillator pair, clear both counters, gate them
//    for a fixed window, then compare the two counts.
//  - Builds NUM_BITS response bits into a register and flags ties and saturation.
//  - Drives the mux select, the ring gate, and the active-high counter reset.

---
 rtl/puf_response_ctrl_if.sv | 33 +++
 rtl/puf_response_ctrl.sv | 168 ++++++++++++++++
 tb/tb_puf_response_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/puf_response_ctrl_if.sv
// Signal bundle between the PUF measurement sequencer and its environment:
// the start/done handshake, the two edge counts, the RO mux/gate/clear
// controls and the response result.
interface puf_response_ctrl_if #(
  parameter int CNT_W    = 16,
  parameter int NUM_BITS = 8,
  parameter int SEL_W    = 3
);
  logic                start;
  logic [CNT_W-1:0]    cnt_a;
  logic [CNT_W-1:0]    cnt_b;
  logic [SEL_W-1:0]    ro_sel;
  logic                ro_en;
  logic                cnt_clr;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] response;
  logic [NUM_BITS-1:0] tie_mask;
  logic                sat;
  logic                resp_valid;

  // Sequencer side.
  modport master (
    input  start, cnt_a, cnt_b,
    output ro_sel, ro_en, cnt_clr, busy, done, response, tie_mask, sat, resp_valid
  );

  // Host / counter side.
  modport slave (
    output start, cnt_a, cnt_b,
    input  ro_sel, ro_en, cnt_clr, busy, done, response, tie_mask, sat, resp_valid
  );
endinterface

// File: rtl/puf_response_ctrl.sv
// PUF response sequencer: for each RO pair, clear both counters, let them
// settle, gate the rings for a fixed window, wait for in-flight edges, then
// compare the two counts into one response bit.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | pair selected, counters cleared (1 cycle)
// SETTLE | SETTLE_CYC cycles of quiet after the clear
// COUNT  | WINDOW cycles with the rings gated on
// HOLD   | HOLD_CYC cycles so the last edges reach the counters
// CMP    | sample cnt_a/cnt_b and record one response bit (1 cycle)
// DONE   | run complete, result published (1 cycle)
//
// Outputs are registered images of the current state, so every output
// shows the state of the previous cycle. busy also lags by one cycle, and a
// start is only taken while both the state and busy say idle, which keeps
// the visible done/busy cycle from accepting a new run.
module puf_response_ctrl #(
  parameter int CNT_W      = 16,
  parameter int NUM_BITS   = 8,
  parameter int SEL_W      = 3,
  parameter int WINDOW     = 1024,
  parameter int SETTLE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input logic clk,
  input logic rst_n,
  puf_response_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SETTLE, COUNT, HOLD, CMP, DONE
  } state_t;

  localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ?
                           ((WINDOW > HOLD_CYC) ? WINDOW : HOLD_CYC) :
                           ((SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] LD_SETTLE = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] LD_WINDOW = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] LD_HOLD   = TMR_W'(HOLD_CYC - 1);
  localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = {CNT_W{1'b1}};

  state_t              state, state_nxt;
  logic [TMR_W-1:0]    tmr, tmr_nxt;
  logic [SEL_W-1:0]    idx, idx_nxt;
  logic [NUM_BITS-1:0] resp_q, resp_nxt;
  logic [NUM_BITS-1:0] tie_q, tie_nxt;
  logic                sat_q, sat_nxt;
  logic                rv_q, rv_nxt;
  logic [SEL_W-1:0]    ro_sel_q;
  logic                ro_en_q, cnt_clr_q, busy_q, done_q;

  // Next-state, phase timer, pair index and result bookkeeping.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    idx_nxt   = idx;
    resp_nxt  = resp_q;
    tie_nxt   = tie_q;
    sat_nxt   = sat_q;
    rv_nxt    = rv_q;
    case (state)
      IDLE: begin
        if (bus.start && !busy_q) begin
          idx_nxt   = '0;
          resp_nxt  = '0;
          tie_nxt   = '0;
          sat_nxt   = 1'b0;
          rv_nxt    = 1'b0;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        tmr_nxt   = LD_SETTLE;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (tmr == '0) begin
          tmr_nxt   = LD_WINDOW;
          state_nxt = COUNT;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      COUNT: begin
        if (tmr == '0) begin
          tmr_nxt   = LD_HOLD;
          state_nxt = HOLD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      HOLD: begin
        if (tmr == '0) state_nxt = CMP;
        else           tmr_nxt   = tmr - 1'b1;
      end
      CMP: begin
        resp_nxt[idx] = (bus.cnt_a > bus.cnt_b);
        tie_nxt[idx]  = (bus.cnt_a == bus.cnt_b);
        sat_nxt       = sat_q | (bus.cnt_a == CNT_FULL) | (bus.cnt_b == CNT_FULL);
        if (idx == IDX_LAST) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = CLEAR;
        end
      end
      DONE: begin
        rv_nxt    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tmr    <= '0;
      idx    <= '0;
      resp_q <= '0;
      tie_q  <= '0;
      sat_q  <= 1'b0;
      rv_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tmr    <= tmr_nxt;
      idx    <= idx_nxt;
      resp_q <= resp_nxt;
      tie_q  <= tie_nxt;
      sat_q  <= sat_nxt;
      rv_q   <= rv_nxt;
    end
  end

  // Registered control outputs decoded from the current state; counters are
  // held cleared while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_sel_q  <= '0;
      ro_en_q   <= 1'b0;
      cnt_clr_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (state == CLEAR) ro_sel_q <= idx;
      ro_en_q   <= (state == COUNT);
      cnt_clr_q <= (state == CLEAR);
      busy_q    <= (state != IDLE);
      done_q    <= (state == DONE);
    end
  end

  assign bus.ro_sel     = ro_sel_q;
  assign bus.ro_en      = ro_en_q;
  assign bus.cnt_clr    = cnt_clr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.response   = resp_q;
  assign bus.tie_mask   = tie_q;
  assign bus.sat        = sat_q;
  assign bus.resp_valid = rv_q;

endmodule

// File: tb/tb_puf_response_ctrl.sv
// Bench for puf_response_ctrl with 4 pairs, WINDOW=16, SETTLE=2, HOLD=2
// (22 cycles per bit, done 89 cycles after the accept edge).
module tb_puf_response_ctrl;
  localparam int CNT_W = 16;
  localparam int NB    = 4;
  localparam int SEL_W = 2;
  localparam int LAT   = 89;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  puf_response_ctrl_if #(.CNT_W(CNT_W), .NUM_BITS(NB), .SEL_W(SEL_W)) bus();

  puf_response_ctrl #(
    .CNT_W(CNT_W), .NUM_BITS(NB), .SEL_W(SEL_W),
    .WINDOW(16), .SETTLE_CYC(2), .HOLD_CYC(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Counter model: each pair returns a fixed count, selected by ro_sel.
  logic [NB-1:0][CNT_W-1:0] pa, pb;
  assign bus.cnt_a = pa[bus.ro_sel];
  assign bus.cnt_b = pb[bus.ro_sel];

  typedef struct {
    logic [NB-1:0][CNT_W-1:0] a;
    logic [NB-1:0][CNT_W-1:0] b;
    logic [NB-1:0]            resp;
    logic [NB-1:0]            tie;
    logic                     sat;
    bit                       inject;
  } vec_t;

  vec_t vecs[5];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int v);
    int cyc, lat, done_cnt, nclr, clr_run, clr_max, en_cnt, en_run, en_max;
    logic [7:0] sel_log;
    pa = vecs[v].a;
    pb = vecs[v].b;
    lat = -1; done_cnt = 0; nclr = 0; clr_run = 0; clr_max = 0;
    en_cnt = 0; en_run = 0; en_max = 0; sel_log = '0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk($sformatf("v%0d rv_clr_on_start", v), {63'd0, bus.resp_valid}, 64'd0);
    chk($sformatf("v%0d sat_clr_on_start", v), {63'd0, bus.sat}, 64'd0);
    for (cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.cnt_clr) begin
        if (nclr < NB) sel_log[2*nclr +: 2] = bus.ro_sel;
        if (clr_run == 0) nclr++;
        clr_run++;
        if (clr_run > clr_max) clr_max = clr_run;
      end else clr_run = 0;
      if (bus.ro_en) begin
        en_cnt++; en_run++;
        if (en_run > en_max) en_max = en_run;
      end else en_run = 0;
      if (vecs[v].inject && (cyc == 5 || cyc == 40 || cyc == LAT - 1)) bus.start = 1'b1;
      if (bus.done) begin
        done_cnt++;
        lat = cyc;
        break;
      end
    end
    if (lat < 0) $display("FAIL v%0d done_timeout: got none expected done", v);
    chk($sformatf("v%0d latency", v), 64'(lat), 64'(LAT));
    chk($sformatf("v%0d response", v), 64'(bus.response), 64'(vecs[v].resp));
    chk($sformatf("v%0d tie_mask", v), 64'(bus.tie_mask), 64'(vecs[v].tie));
    chk($sformatf("v%0d sat", v), {63'd0, bus.sat}, {63'd0, vecs[v].sat});
    chk($sformatf("v%0d resp_valid", v), {63'd0, bus.resp_valid}, 64'd1);
    chk($sformatf("v%0d clr_pulses", v), 64'(nclr), 64'(NB));
    chk($sformatf("v%0d clr_width", v), 64'(clr_max), 64'd1);
    chk($sformatf("v%0d en_cycles", v), 64'(en_cnt), 64'(16 * NB));
    chk($sformatf("v%0d en_run", v), 64'(en_max), 64'd16);
    chk($sformatf("v%0d sel_seq", v), 64'(sel_log), 64'h00E4);
    if (vecs[v].inject) bus.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) done_cnt++;
    end
    chk($sformatf("v%0d done_count", v), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d busy_after", v), {63'd0, bus.busy}, 64'd0);
    chk($sformatf("v%0d rv_held", v), {63'd0, bus.resp_valid}, 64'd1);
    chk($sformatf("v%0d resp_held", v), 64'(bus.response), 64'(vecs[v].resp));
  endtask

  initial begin
    int k, dn;
    vecs[0] = '{a: {16'd100, 16'd100, 16'd100, 16'd100}, b: {16'd90, 16'd90, 16'd90, 16'd90},
                resp: 4'hF, tie: 4'h0, sat: 1'b0, inject: 1'b0};
    vecs[1] = '{a: {16'd0, 16'd7, 16'd9, 16'd5}, b: {16'd1, 16'd7, 16'd5, 16'd9},
                resp: 4'b0010, tie: 4'b0100, sat: 1'b0, inject: 1'b0};
    vecs[2] = '{a: {16'd2, 16'hFFFF, 16'd1, 16'd3}, b: {16'd3, 16'd0, 16'd1, 16'd2},
                resp: 4'b0101, tie: 4'b0010, sat: 1'b1, inject: 1'b0};
    vecs[3] = '{a: {16'd4, 16'd8, 16'hFFFF, 16'd0}, b: {16'd8, 16'd4, 16'hFFFF, 16'hFFFF},
                resp: 4'b0100, tie: 4'b0010, sat: 1'b1, inject: 1'b1};
    vecs[4] = '{a: {16'd0, 16'd1, 16'd0, 16'hFFFE}, b: {16'd0, 16'd0, 16'd0, 16'hFFFD},
                resp: 4'b0101, tie: 4'b1010, sat: 1'b0, inject: 1'b0};
    bus.start = 1'b0;
    pa = '0;
    pb = '0;

    // Reset values.
    #12;
    chk("rst ro_sel", 64'(bus.ro_sel), 64'd0);
    chk("rst ro_en", {63'd0, bus.ro_en}, 64'd0);
    chk("rst cnt_clr", {63'd0, bus.cnt_clr}, 64'd1);
    chk("rst busy", {63'd0, bus.busy}, 64'd0);
    chk("rst done", {63'd0, bus.done}, 64'd0);
    chk("rst response", 64'(bus.response), 64'd0);
    chk("rst tie_mask", 64'(bus.tie_mask), 64'd0);
    chk("rst sat", {63'd0, bus.sat}, 64'd0);
    chk("rst resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle cnt_clr", {63'd0, bus.cnt_clr}, 64'd0);

    for (int v = 0; v < 5; v++) run_vec(v);

    // Reset in the middle of COUNT for bit 1.
    pa = vecs[0].a;
    pb = vecs[0].b;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (bus.ro_en && bus.ro_sel == 2'd1) break;
    end
    chk("mid wait_count_bit1", 64'(k < 200), 64'd1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid ro_en", {63'd0, bus.ro_en}, 64'd0);
    chk("mid cnt_clr", {63'd0, bus.cnt_clr}, 64'd1);
    chk("mid busy", {63'd0, bus.busy}, 64'd0);
    chk("mid response", 64'(bus.response), 64'd0);
    dn = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk("mid no_done", 64'(dn), 64'd0);
    chk("mid idle_busy", {63'd0, bus.busy}, 64'd0);
    run_vec(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
